// File: rtl/prior_encoder_pkg.sv
// Shared types and helpers for the sequential priority-scan encoder.
package prior_encoder_pkg;

    // Scan controller states.
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    // Index width: one extra MSB so that DATA_WIDTH itself ("no bit set") fits.
    function automatic int idx_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/prior_encoder.sv
// Combinational LSB-first find-first-set; returns DATA_WIDTH for an all-zero input.
module prior_encoder #(
    parameter int DATA_WIDTH  = 8,
    parameter int INDEX_WIDTH = $clog2(DATA_WIDTH) + 1
) (
    input  logic [DATA_WIDTH-1:0]  data_in,
    output logic [INDEX_WIDTH-1:0] idx_out
);

    // Walk from the top down so the lowest set bit overwrites last.
    always_comb begin
        idx_out = INDEX_WIDTH'(DATA_WIDTH);
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (data_in[i]) idx_out = INDEX_WIDTH'(i);
        end
    end

endmodule

// File: rtl/prior_scan_encoder.sv
// Sequential priority-scan encoder: accepts a request vector and emits the
// index of each set bit, one beat per handshake, in priority order.
// Optional feature macro PRIOR_SCAN_SEQ_EN adds the out_seq beat-ordinal port.
module prior_scan_encoder
    import prior_encoder_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int INDEX_WIDTH = idx_width(DATA_WIDTH),
    parameter bit MSB_FIRST   = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INDEX_WIDTH-1:0] out_idx,
    output logic                   out_last,
    output logic                   out_none
`ifdef PRIOR_SCAN_SEQ_EN
    ,
    output logic [INDEX_WIDTH-1:0] out_seq
`endif
);

    localparam logic [INDEX_WIDTH-1:0] LAST_POS = INDEX_WIDTH'(DATA_WIDTH - 1);
    localparam logic [INDEX_WIDTH-1:0] NONE_IDX = INDEX_WIDTH'(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0]  ONE      = DATA_WIDTH'(1);

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   mask_q, mask_d;
    logic                    none_q, none_d;
`ifdef PRIOR_SCAN_SEQ_EN
    logic [INDEX_WIDTH-1:0]  seq_q, seq_d;
`endif

    logic [DATA_WIDTH-1:0]   scan_vec;
    logic [DATA_WIDTH-1:0]   clr_mask;
    logic [INDEX_WIDTH-1:0]  enc_idx;
    logic [INDEX_WIDTH-1:0]  bit_pos;
    logic                    scan;
    logic                    multi;
    logic                    handshake;
    logic                    accept;

    // Present the mask to the LSB-first encoder, bit-reversed for MSB-first order.
    always_comb begin
        scan_vec = mask_q;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            scan_vec[i] = MSB_FIRST ? mask_q[DATA_WIDTH-1-i] : mask_q[i];
        end
    end

    prior_encoder #(
        .DATA_WIDTH  (DATA_WIDTH),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_enc (
        .data_in (scan_vec),
        .idx_out (enc_idx)
    );

    // Map the encoder result back to a mask position and one-hot decode it for clearing.
    always_comb begin
        bit_pos  = MSB_FIRST ? (LAST_POS - enc_idx) : enc_idx;
        clr_mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            clr_mask[i] = (bit_pos == INDEX_WIDTH'(i));
        end
    end

    assign scan      = (state_q == SCAN);
    assign multi     = |(mask_q & (mask_q - ONE));
    assign out_valid = scan;
    assign out_last  = scan && (none_q || !multi);
    assign out_none  = scan && none_q;
    assign out_idx   = !scan ? '0 : (none_q ? NONE_IDX : bit_pos);
    assign handshake = scan && out_ready;
    // Accept in IDLE, or on the final beat so consecutive vectors run without a bubble.
    assign in_ready  = !rst && (!scan || (out_ready && out_last));
    assign accept    = in_valid && in_ready;
`ifdef PRIOR_SCAN_SEQ_EN
    assign out_seq   = scan ? seq_q : '0;
`endif

    // Next-state: retire the reported bit on a handshake; a new accept overrides the mask.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        none_d  = none_q;
`ifdef PRIOR_SCAN_SEQ_EN
        seq_d   = seq_q;
`endif
        if (handshake) begin
            mask_d = mask_q & ~clr_mask;
`ifdef PRIOR_SCAN_SEQ_EN
            seq_d  = seq_q + INDEX_WIDTH'(1);
`endif
            if (out_last) begin
                state_d = IDLE;
                none_d  = 1'b0;
            end
        end
        if (accept) begin
            state_d = SCAN;
            mask_d  = in_data;
            none_d  = (in_data == '0);
`ifdef PRIOR_SCAN_SEQ_EN
            seq_d   = '0;
`endif
        end
    end

    // Controller and scan registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            none_q  <= 1'b0;
`ifdef PRIOR_SCAN_SEQ_EN
            seq_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            none_q  <= none_d;
`ifdef PRIOR_SCAN_SEQ_EN
            seq_q   <= seq_d;
`endif
        end
    end

endmodule

// File: tb/tb_prior_scan_encoder.sv
// Bench for prior_scan_encoder: an LSB-first and an MSB-first instance share stimulus.
module tb_prior_scan_encoder;

    localparam int DW = 8;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;

    logic          rdy0, v0, last0, none0;
    logic [IW-1:0] idx0;
    logic          rdy1, v1, last1, none1;
    logic [IW-1:0] idx1;
`ifdef PRIOR_SCAN_SEQ_EN
    logic [IW-1:0] seq0, seq1;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: remaining beats per instance (value DW means "none").
    int q0[$];
    int q1[$];
    int mseq;

    always #5 clk = ~clk;

    prior_scan_encoder #(.DATA_WIDTH(DW), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .out_valid(v0), .out_ready(out_ready), .out_idx(idx0), .out_last(last0),
        .out_none(none0)
`ifdef PRIOR_SCAN_SEQ_EN
        , .out_seq(seq0)
`endif
    );

    prior_scan_encoder #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .out_valid(v1), .out_ready(out_ready), .out_idx(idx1), .out_last(last1),
        .out_none(none1)
`ifdef PRIOR_SCAN_SEQ_EN
        , .out_seq(seq1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic model_load(input logic [DW-1:0] v);
        q0.delete(); q1.delete(); mseq = 0;
        for (int i = 0; i < DW; i++) if (v[i]) q0.push_back(i);
        for (int i = DW - 1; i >= 0; i--) if (v[i]) q1.push_back(i);
        if (v == '0) begin q0.push_back(DW); q1.push_back(DW); end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
        tick(); tick();
        total++;
        if (rdy0 !== 1'b0 || v0 !== 1'b0 || idx0 !== 4'd0 || last0 !== 1'b0 || none0 !== 1'b0) begin
            bad++;
            $display("FAIL reset_state rdy=%b valid=%b idx=%0d last=%b none=%b want 0/0/0/0/0",
                     rdy0, v0, idx0, last0, none0);
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        total++;
        if (rdy0 !== 1'b1 || v0 !== 1'b0) begin
            bad++;
            $display("FAIL reset_release rdy=%b valid=%b want 1/0", rdy0, v0);
        end
    endtask

    task automatic test_scan_order();
        int exp_lsb[3] = '{2, 5, 7};
        int exp_msb[3] = '{7, 5, 2};
        do_reset();
        in_valid = 1'b1; in_data = 8'b1010_0100; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            #1;
            total++;
            if (v0 !== 1'b1 || idx0 !== IW'(exp_lsb[b]) || last0 !== (b == 2) || none0 !== 1'b0) begin
                bad++;
                $display("FAIL scan_lsb beat%0d valid=%b idx=%0d last=%b want 1/%0d/%0d",
                         b, v0, idx0, last0, exp_lsb[b], (b == 2));
            end
            total++;
            if (v1 !== 1'b1 || idx1 !== IW'(exp_msb[b]) || last1 !== (b == 2)) begin
                bad++;
                $display("FAIL scan_msb beat%0d valid=%b idx=%0d last=%b want 1/%0d/%0d",
                         b, v1, idx1, last1, exp_msb[b], (b == 2));
            end
`ifdef PRIOR_SCAN_SEQ_EN
            total++;
            if (seq0 !== IW'(b)) begin
                bad++;
                $display("FAIL seq beat%0d got=%0d want=%0d", b, seq0, b);
            end
`endif
            tick();
        end
        total++;
        if (v0 !== 1'b0 || rdy0 !== 1'b1 || idx0 !== 4'd0) begin
            bad++;
            $display("FAIL scan_idle valid=%b rdy=%b idx=%0d want 0/1/0", v0, rdy0, idx0);
        end
    endtask

    task automatic test_zero();
        do_reset();
        in_valid = 1'b1; in_data = 8'h00; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        total++;
        if (v0 !== 1'b1 || idx0 !== 4'd8 || none0 !== 1'b1 || last0 !== 1'b1 ||
            idx1 !== 4'd8 || none1 !== 1'b1) begin
            bad++;
            $display("FAIL zero_beat valid=%b idx=%0d none=%b last=%b idx1=%0d want 1/8/1/1/8",
                     v0, idx0, none0, last0, idx1);
        end
`ifdef PRIOR_SCAN_SEQ_EN
        total++;
        if (seq0 !== 4'd0) begin bad++; $display("FAIL zero_seq got=%0d want=0", seq0); end
`endif
        tick();
        total++;
        if (v0 !== 1'b0 || none0 !== 1'b0) begin
            bad++;
            $display("FAIL zero_after valid=%b none=%b want 0/0", v0, none0);
        end
    endtask

    task automatic test_msb_first();
        do_reset();
        in_valid = 1'b1; in_data = 8'b0000_0011; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        total++;
        if (v1 !== 1'b1 || idx1 !== 4'd1 || last1 !== 1'b0) begin
            bad++;
            $display("FAIL msb_beat0 valid=%b idx=%0d last=%b want 1/1/0", v1, idx1, last1);
        end
        tick();
        total++;
        if (v1 !== 1'b1 || idx1 !== 4'd0 || last1 !== 1'b1) begin
            bad++;
            $display("FAIL msb_beat1 valid=%b idx=%0d last=%b want 1/0/1", v1, idx1, last1);
        end
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid = 1'b1; in_data = 8'h81; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (v0 !== 1'b1 || idx0 !== 4'd0 || last0 !== 1'b0 || rdy0 !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold c%0d valid=%b idx=%0d last=%b rdy=%b want 1/0/0/0",
                         c, v0, idx0, last0, rdy0);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (v0 !== 1'b1 || idx0 !== 4'd0 || last0 !== 1'b0) begin
            bad++;
            $display("FAIL bp_rel0 valid=%b idx=%0d last=%b want 1/0/0", v0, idx0, last0);
        end
        tick();
        total++;
        if (v0 !== 1'b1 || idx0 !== 4'd7 || last0 !== 1'b1) begin
            bad++;
            $display("FAIL bp_rel1 valid=%b idx=%0d last=%b want 1/7/1", v0, idx0, last0);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        in_valid = 1'b1; in_data = 8'h01; out_ready = 1'b1;
        tick();
        in_data = 8'h80;
        #1;
        total++;
        if (v0 !== 1'b1 || idx0 !== 4'd0 || last0 !== 1'b1 || rdy0 !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first valid=%b idx=%0d last=%b rdy=%b want 1/0/1/1",
                     v0, idx0, last0, rdy0);
        end
        tick();
        in_valid = 1'b0;
        #1;
        total++;
        if (v0 !== 1'b1 || idx0 !== 4'd7 || last0 !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second valid=%b idx=%0d last=%b want 1/7/1", v0, idx0, last0);
        end
        tick();
        total++;
        if (v0 !== 1'b0) begin bad++; $display("FAIL b2b_idle valid=%b want 0", v0); end
    endtask

    task automatic test_reset_mid_scan();
        do_reset();
        in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        total++;
        if (v0 !== 1'b1 || idx0 !== 4'd0) begin
            bad++;
            $display("FAIL rmid_beat0 valid=%b idx=%0d want 1/0", v0, idx0);
        end
        tick();
        rst = 1'b1;
        #1;
        total++;
        if (v0 !== 1'b1 || idx0 !== 4'd1 || rdy0 !== 1'b0) begin
            bad++;
            $display("FAIL rmid_beat1 valid=%b idx=%0d rdy=%b want 1/1/0", v0, idx0, rdy0);
        end
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (v0 !== 1'b0 || rdy0 !== 1'b1 || idx0 !== 4'd0) begin
            bad++;
            $display("FAIL rmid_after valid=%b rdy=%b idx=%0d want 0/1/0", v0, rdy0, idx0);
        end
    endtask

    task automatic test_random();
        int e0, e1;
        logic exp_v, exp_rdy, exp_last, exp_none;
        do_reset();
        q0.delete(); q1.delete(); mseq = 0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = ($urandom_range(0, 5) == 0) ? 8'h00 : DW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_v    = (q0.size() > 0);
            exp_rdy  = (q0.size() == 0) || (out_ready && q0.size() == 1);
            e0       = exp_v ? q0[0] : 0;
            e1       = exp_v ? q1[0] : 0;
            exp_last = exp_v && (q0.size() == 1);
            exp_none = exp_v && (q0[0] == DW);
            total++;
            if (v0 !== exp_v || rdy0 !== exp_rdy || idx0 !== IW'(e0) ||
                last0 !== exp_last || none0 !== exp_none) begin
                bad++;
                $display("FAIL rand_lsb c%0d v=%b rdy=%b idx=%0d last=%b none=%b want %b/%b/%0d/%b/%b",
                         c, v0, rdy0, idx0, last0, none0, exp_v, exp_rdy, e0, exp_last, exp_none);
            end
            total++;
            if (v1 !== exp_v || rdy1 !== exp_rdy || idx1 !== IW'(e1) ||
                last1 !== exp_last || none1 !== exp_none) begin
                bad++;
                $display("FAIL rand_msb c%0d v=%b rdy=%b idx=%0d last=%b none=%b want %b/%b/%0d/%b/%b",
                         c, v1, rdy1, idx1, last1, none1, exp_v, exp_rdy, e1, exp_last, exp_none);
            end
`ifdef PRIOR_SCAN_SEQ_EN
            total++;
            if (seq0 !== IW'(exp_v ? mseq : 0) || seq1 !== seq0) begin
                bad++;
                $display("FAIL rand_seq c%0d got=%0d/%0d want=%0d", c, seq0, seq1, exp_v ? mseq : 0);
            end
`endif
            tick();
            if (exp_v && out_ready) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
                mseq++;
            end
            if (in_valid && exp_rdy) model_load(in_data);
        end
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_zero();
        test_msb_first();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_scan();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
